// File: rtl/hdu.sv
// Hazard detection unit: register scoreboard for long-latency results,
// RAW/WAW/load-use stall generation, branch flush control and a
// saturating stall-cycle counter.
module hdu (
    input  logic        clk,
    input  logic        rst,
    input  logic        IdValidIn,
    input  logic [4:0]  Rs1AddrIdIn,
    input  logic [4:0]  Rs2AddrIdIn,
    input  logic        Rs1ReadEnableIdIn,
    input  logic        Rs2ReadEnableIdIn,
    input  logic [4:0]  RdAddrIdIn,
    input  logic        RdWriteEnableIdIn,
    input  logic        LongLatIdIn,
    input  logic [4:0]  RdAddrId2ExIn,
    input  logic        RdWriteEnableId2ExIn,
    input  logic        LoadId2ExIn,
    input  logic        WbValidIn,
    input  logic [4:0]  WbRdAddrIn,
    input  logic        BranchTakenIn,
    output logic        StallIdOut,
    output logic        FlushIfIdOut,
    output logic        FlushId2ExOut,
    output logic        AnyPendingOut,
    output logic [31:0] StallCntOut
);

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [31:1] pending;
    logic [31:0] pend_view;
    logic [31:0] pend_next;
    logic        any_pending;
    logic [31:0] stall_cnt;

    logic raw1;
    logic raw2;
    logic waw;
    logic load_use;
    logic stall;
    logic issue;
    logic set_req;

    // Scoreboard as seen by the hazard checks: hidden while in reset, and a
    // result retiring this cycle no longer counts as pending for readers.
    always_comb begin
        pend_view = '0;
        if (!rst) begin
            pend_view[31:1] = pending;
        end
        if (WbValidIn) begin
            pend_view[WbRdAddrIn] = 1'b0;
        end
        pend_view[0] = 1'b0;
    end

    assign raw1 = IdValidIn && Rs1ReadEnableIdIn && (Rs1AddrIdIn != 5'd0)
                  && pend_view[Rs1AddrIdIn];
    assign raw2 = IdValidIn && Rs2ReadEnableIdIn && (Rs2AddrIdIn != 5'd0)
                  && pend_view[Rs2AddrIdIn];
    assign waw  = IdValidIn && RdWriteEnableIdIn && (RdAddrIdIn != 5'd0)
                  && pend_view[RdAddrIdIn];

    assign load_use = IdValidIn && LoadId2ExIn && RdWriteEnableId2ExIn
                      && (RdAddrId2ExIn != 5'd0)
                      && ((Rs1ReadEnableIdIn && (Rs1AddrIdIn != 5'd0)
                           && (Rs1AddrIdIn == RdAddrId2ExIn))
                       || (Rs2ReadEnableIdIn && (Rs2AddrIdIn != 5'd0)
                           && (Rs2AddrIdIn == RdAddrId2ExIn)));

    assign stall   = (raw1 || raw2 || waw || load_use) && !BranchTakenIn;
    assign issue   = IdValidIn && !stall && !BranchTakenIn;
    assign set_req = issue && RdWriteEnableIdIn && LongLatIdIn
                     && (RdAddrIdIn != 5'd0);

    // Next scoreboard state: retirement clears first so a same-cycle issue
    // to the same register leaves the bit set.
    always_comb begin
        pend_next = {pending, 1'b0};
        if (WbValidIn && (WbRdAddrIn != 5'd0)) begin
            pend_next[WbRdAddrIn] = 1'b0;
        end
        if (set_req) begin
            pend_next[RdAddrIdIn] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    // Scoreboard and its summary flag update together, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= '0;
            any_pending <= 1'b0;
        end else begin
            pending     <= pend_next[31:1];
            any_pending <= |pend_next[31:1];
        end
    end

    // Stall-cycle counter that sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign StallIdOut    = stall;
    assign FlushIfIdOut  = BranchTakenIn;
    assign FlushId2ExOut = BranchTakenIn || stall;
    assign AnyPendingOut = any_pending;
    assign StallCntOut   = stall_cnt;

endmodule

// File: tb/tb_hdu.sv
// Directed self-checking bench for the hazard detection unit.
module tb_hdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        IdValidIn;
    logic [4:0]  Rs1AddrIdIn;
    logic [4:0]  Rs2AddrIdIn;
    logic        Rs1ReadEnableIdIn;
    logic        Rs2ReadEnableIdIn;
    logic [4:0]  RdAddrIdIn;
    logic        RdWriteEnableIdIn;
    logic        LongLatIdIn;
    logic [4:0]  RdAddrId2ExIn;
    logic        RdWriteEnableId2ExIn;
    logic        LoadId2ExIn;
    logic        WbValidIn;
    logic [4:0]  WbRdAddrIn;
    logic        BranchTakenIn;
    logic        StallIdOut;
    logic        FlushIfIdOut;
    logic        FlushId2ExOut;
    logic        AnyPendingOut;
    logic [31:0] StallCntOut;

    int n_checks = 0;
    int n_fail   = 0;

    hdu dut (
        .clk(clk),
        .rst(rst),
        .IdValidIn(IdValidIn),
        .Rs1AddrIdIn(Rs1AddrIdIn),
        .Rs2AddrIdIn(Rs2AddrIdIn),
        .Rs1ReadEnableIdIn(Rs1ReadEnableIdIn),
        .Rs2ReadEnableIdIn(Rs2ReadEnableIdIn),
        .RdAddrIdIn(RdAddrIdIn),
        .RdWriteEnableIdIn(RdWriteEnableIdIn),
        .LongLatIdIn(LongLatIdIn),
        .RdAddrId2ExIn(RdAddrId2ExIn),
        .RdWriteEnableId2ExIn(RdWriteEnableId2ExIn),
        .LoadId2ExIn(LoadId2ExIn),
        .WbValidIn(WbValidIn),
        .WbRdAddrIn(WbRdAddrIn),
        .BranchTakenIn(BranchTakenIn),
        .StallIdOut(StallIdOut),
        .FlushIfIdOut(FlushIfIdOut),
        .FlushId2ExOut(FlushId2ExOut),
        .AnyPendingOut(AnyPendingOut),
        .StallCntOut(StallCntOut)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; inputs change 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Quiet ID stage: no valid instruction, nothing read or written.
    task automatic idle_id();
        IdValidIn         = 1'b0;
        Rs1AddrIdIn       = 5'd0;
        Rs2AddrIdIn       = 5'd0;
        Rs1ReadEnableIdIn = 1'b0;
        Rs2ReadEnableIdIn = 1'b0;
        RdAddrIdIn        = 5'd0;
        RdWriteEnableIdIn = 1'b0;
        LongLatIdIn       = 1'b0;
    endtask

    task automatic id_instr(input logic [4:0] rs1, input logic en1,
                            input logic [4:0] rs2, input logic en2,
                            input logic [4:0] rd, input logic we,
                            input logic ll);
        IdValidIn         = 1'b1;
        Rs1AddrIdIn       = rs1;
        Rs1ReadEnableIdIn = en1;
        Rs2AddrIdIn       = rs2;
        Rs2ReadEnableIdIn = en2;
        RdAddrIdIn        = rd;
        RdWriteEnableIdIn = we;
        LongLatIdIn       = ll;
    endtask

    initial begin
        rst                  = 1'b1;
        idle_id();
        RdAddrId2ExIn        = 5'd0;
        RdWriteEnableId2ExIn = 1'b0;
        LoadId2ExIn          = 1'b0;
        WbValidIn            = 1'b0;
        WbRdAddrIn           = 5'd0;
        BranchTakenIn        = 1'b0;

        // Reset state
        step();
        check("rst_stall", StallIdOut, 0);
        check("rst_flush_ifid", FlushIfIdOut, 0);
        check("rst_flush_idex", FlushId2ExOut, 0);
        check("rst_anypend", AnyPendingOut, 0);
        check("rst_cnt", StallCntOut, 0);
        rst = 1'b0;
        step();

        // Load-use: load to x5 in EX, ID reads x5 on rs1
        RdAddrId2ExIn = 5'd5; RdWriteEnableId2ExIn = 1'b1; LoadId2ExIn = 1'b1;
        id_instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        check("lu_stall", StallIdOut, 1);
        check("lu_flush_idex", FlushId2ExOut, 1);
        check("lu_flush_ifid", FlushIfIdOut, 0);
        step();
        RdAddrId2ExIn = 5'd0; RdWriteEnableId2ExIn = 1'b0; LoadId2ExIn = 1'b0;
        #1;
        check("lu_release", StallIdOut, 0);
        check("lu_cnt", StallCntOut, 1);
        step();

        // Long-latency: div to x7, then reader of x7 on rs2
        id_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        #1;
        check("div_issue_nostall", StallIdOut, 0);
        step();
        check("div_anypend", AnyPendingOut, 1);
        id_instr(5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
        #1;
        check("div_raw_stall", StallIdOut, 1);
        step();
        check("div_raw_hold", StallIdOut, 1);
        check("div_cnt2", StallCntOut, 2);
        step();
        check("div_cnt3", StallCntOut, 3);
        WbValidIn = 1'b1; WbRdAddrIn = 5'd7;
        #1;
        check("div_wb_nostall", StallIdOut, 0);
        check("div_wb_flush_idex", FlushId2ExOut, 0);
        step();
        WbValidIn = 1'b0; WbRdAddrIn = 5'd0;
        check("div_anypend_clr", AnyPendingOut, 0);
        check("div_cnt_held", StallCntOut, 3);

        // Long op to x0 never becomes pending
        id_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        step();
        check("x0_anypend", AnyPendingOut, 0);

        // Make x5 pending, then a disabled read of x5 does not stall
        id_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        step();
        check("x5_anypend", AnyPendingOut, 1);
        id_instr(5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        check("dis_read_nostall", StallIdOut, 0);
        id_instr(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        check("rs2_raw_stall", StallIdOut, 1);
        id_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        #1;
        check("waw_stall", StallIdOut, 1);

        // Branch priority: RAW on x5 plus long op to x6, branch taken
        id_instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        BranchTakenIn = 1'b1;
        #1;
        check("br_nostall", StallIdOut, 0);
        check("br_flush_ifid", FlushIfIdOut, 1);
        check("br_flush_idex", FlushId2ExOut, 1);
        step();
        BranchTakenIn = 1'b0;
        id_instr(5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        check("br_no_set_x6", StallIdOut, 0);
        check("br_cnt", StallCntOut, 3);

        // Retire x5
        idle_id();
        WbValidIn = 1'b1; WbRdAddrIn = 5'd5;
        step();
        WbValidIn = 1'b0; WbRdAddrIn = 5'd0;
        check("x5_clr_anypend", AnyPendingOut, 0);

        // Same-cycle set and clear of x9: set wins
        id_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        step();
        WbValidIn = 1'b1; WbRdAddrIn = 5'd9;
        #1;
        check("x9_reissue_nostall", StallIdOut, 0);
        step();
        WbValidIn = 1'b0; WbRdAddrIn = 5'd0;
        check("x9_anypend", AnyPendingOut, 1);
        id_instr(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        check("x9_still_pending", StallIdOut, 1);

        // Unmatched retirement and retirement of x0 are harmless
        idle_id();
        WbValidIn = 1'b1; WbRdAddrIn = 5'd12;
        step();
        WbRdAddrIn = 5'd0;
        step();
        WbValidIn = 1'b0;
        check("unmatched_wb_anypend", AnyPendingOut, 1);

        // Saturation: preload near the top, then stall twice on x9
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        id_instr(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        check("sat_reach", StallCntOut, 32'hFFFF_FFFF);
        step();
        check("sat_hold", StallCntOut, 32'hFFFF_FFFF);

        // Make x3 pending; x9 stays pending
        id_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
        #1;
        check("x3_issue_nostall", StallIdOut, 0);
        step();

        // Reset with x3 pending and a long op to x4 trying to issue
        rst = 1'b1;
        id_instr(5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        #1;
        check("rst_x3_nostall", StallIdOut, 0);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_cnt", StallCntOut, 0);
        check("post_rst_anypend", AnyPendingOut, 0);
        check("post_rst_x3_nostall", StallIdOut, 0);
        id_instr(5'd9, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        check("post_rst_x9_x4_nostall", StallIdOut, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hdu.md
HDU -- requirements
Module: Hdu

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 IdValidIn  input  1  a valid instruction is in the ID stage.
REQ-004 Rs1AddrIdIn / Rs2AddrIdIn  input  5 each  source register addresses of the ID instruction.
REQ-005 Rs1ReadEnableIdIn / Rs2ReadEnableIdIn  input  1 each  source register is actually read.
REQ-006 RdAddrIdIn  input  5  destination register of the ID instruction.
REQ-007 RdWriteEnableIdIn  input  1  the ID instruction writes its destination register.
REQ-008 LongLatIdIn  input  1  the ID instruction is long-latency (load, mul or div), so its result is not forwardable from Ex2Mem.
REQ-009 RdAddrId2ExIn  input  5  destination register of the instruction in EX.
REQ-010 RdWriteEnableId2ExIn  input  1  the EX instruction writes its destination register.
REQ-011 LoadId2ExIn  input  1  the EX instruction is a load.
REQ-012 WbValidIn  input  1  a long-latency result is retiring this cycle.
REQ-013 WbRdAddrIn  input  5  destination register of the retiring long-latency result.
REQ-014 BranchTakenIn  input  1  EX resolved a redirect this cycle.
REQ-015 StallIdOut  output  1  hold the PC and the IF/ID register.
REQ-016 FlushIfIdOut  output  1  clear IF/ID to a bubble.
REQ-017 FlushId2ExOut  output  1  load a bubble into ID/EX.
REQ-018 AnyPendingOut  output  1  at least one scoreboard bit is set.
REQ-019 StallCntOut  output  32  saturating count of stall cycles.

Function
REQ-020 Scoreboard: Pending[31:1] SHALL be a set of registered bits; Pending[0] SHALL read as 0 and SHALL never be set.
REQ-021 Issue is defined as IdValidIn && !StallIdOut && !BranchTakenIn.
REQ-022 Set rule: Pending[RdAddrIdIn] SHALL be set at the edge when issue && RdWriteEnableIdIn && LongLatIdIn && RdAddrIdIn!=0.
REQ-023 Clear rule: Pending[WbRdAddrIn] SHALL be cleared at the edge when WbValidIn=1.
REQ-024 If a set and a clear target the same register in one cycle, set SHALL win and the bit SHALL be 1 afterwards.
REQ-025 Effective pending: EffPend[r] = Pending[r] && !(WbValidIn && WbRdAddrIn==r). A retiring result therefore SHALL NOT stall a reader in the same cycle.
REQ-026 RAW hazard: IdValidIn && RsxReadEnableIdIn && RsxAddr!=0 && EffPend[RsxAddr], evaluated for x=1 and x=2.
REQ-027 WAW hazard: IdValidIn && RdWriteEnableIdIn && RdAddrIdIn!=0 && EffPend[RdAddrIdIn].
REQ-028 Load-use hazard: IdValidIn && LoadId2ExIn && RdWriteEnableId2ExIn && RdAddrId2ExIn!=0 && RdAddrId2ExIn matches an enabled, nonzero rs.
REQ-029 StallIdOut SHALL be combinational, = (RAW || WAW || load-use) && !BranchTakenIn.
REQ-030 FlushIfIdOut SHALL equal BranchTakenIn.
REQ-031 FlushId2ExOut SHALL equal BranchTakenIn || StallIdOut. Each stall cycle therefore inserts exactly one bubble.
REQ-032 Load-use stall latency: exactly 1 cycle, after which the load has advanced to Mem and the forwarding unit supplies the data. Long-latency stalls SHALL last until the matching WbValidIn cycle, inclusive of REQ-025.
REQ-033 AnyPendingOut SHALL be the registered OR of Pending[31:1], i.e. it reflects post-edge state.
REQ-034 StallCntOut SHALL increment by 1 at each edge where StallIdOut=1 and SHALL saturate at 32'hFFFF_FFFF with no wrap.
REQ-035 An unmatched WbValidIn (bit already 0) SHALL be harmless, and WbRdAddrIn=0 SHALL be ignored.

Reset
REQ-036 With rst=1 at an edge, Pending SHALL become all 0 and StallCntOut SHALL become 0, overriding any same-cycle set.
REQ-037 While rst=1, combinational outputs SHALL follow REQ-029 to REQ-031 using the cleared scoreboard. After the first reset edge: StallIdOut=0, FlushIfIdOut=BranchTakenIn, FlushId2ExOut=BranchTakenIn, AnyPendingOut=0.
REQ-038 Reset asserted mid-stall SHALL release a long-latency stall at the next edge.

Verification
REQ-039 Load-use: EX holds a load to x5; ID reads rs1=x5 -> StallIdOut=1 and FlushId2ExOut=1 for 1 cycle; next cycle, with EX holding the bubble, StallIdOut=0; StallCntOut=1.
REQ-040 Long-latency: issue div to x7; next instruction reads rs2=x7 -> stall held until the WbValidIn/x7 cycle, where StallIdOut=0 in that same cycle; AnyPendingOut 1 then 0.
REQ-041 x0 and disabled reads: long op to x0, or rs1=x5 with Rs1ReadEnableIdIn=0 against pending x5 -> no stall, Pending unchanged.
REQ-042 Branch priority: RAW hazard and BranchTakenIn=1 together -> StallIdOut=0, both flushes=1, and no scoreboard set from the ID instruction.
REQ-043 Same-cycle set and clear: WbValidIn for x9 while a new long op to x9 issues -> Pending[9]=1 afterwards, AnyPendingOut=1.
REQ-044 Reset and saturation: preload StallCntOut at 32'hFFFF_FFFF and stall one more cycle -> count stays at FFFF_FFFF; assert rst with x3 pending -> count=0, Pending=0, x3 reader not stalled.
